// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and constants for the DDR user-port arbiter.
//   state_t        arbiter FSM states
//   DDR_CMD_*      DDR3 IP user-interface command encodings
//   DEF_*          default address / data / mask widths
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        WAIT_CAL = 3'd0,
        ARB      = 3'd1,
        CMD      = 3'd2,
        WDATA    = 3'd3,
        RDATA    = 3'd4
    } state_t;

    localparam logic [2:0] DDR_CMD_READ  = 3'b001;
    localparam logic [2:0] DDR_CMD_WRITE = 3'b000;

    localparam int DEF_ADDR_W = 29;
    localparam int DEF_DATA_W = 256;
    localparam int DEF_MASK_W = 32;

endpackage

// File: rtl/ddr_arb_grant.sv
// ddr_arb_grant: combinational one-hot grant selection.
//   req_valid  in   pending requests, one bit per requester
//   grant      out  one-hot winner (all zero when nothing pending)
// Optional build macro ARB_ROUND_ROBIN_EN:
//   undefined  fixed priority, highest index wins, purely combinational
//   defined    round-robin; adds clk/rst/take ports and a last-grant
//              pointer that advances whenever take is high
module ddr_arb_grant #(
    parameter int NREQ = 2
) (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic            clk,
    input  logic            rst,
    input  logic            take,
`endif
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] last;
    logic [PW-1:0] win;
    logic          found;
    int            idx;

    // Search starts just after the previous winner and wraps to 0.
    always_comb begin
        grant = '0;
        win   = last;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win        = idx[PW-1:0];
                found      = 1'b1;
            end
        end
    end

    // Reset to the top index so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last <= PW'(NREQ - 1);
        else if (take) last <= win;
    end
`else
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares the DDR3 controller user port between NREQ
// requesters (0 = instruction fetch, 1 = MEM load/store). One transaction
// is outstanding at a time; completion goes only to the granted port.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/we/addr/wdata/wmask   requester side, held until req_ready
//   req_ready                 one-hot accept pulse
//   rsp_valid, rsp_rdata      one-hot completion pulse, shared read data
//   init_calib_complete       DDR calibration done
//   ddr_cmd_rdy, ddr_en, ddr_cmd, memory_address     command handshake
//   ddr_write_rdy, ddr_write_en, ddr_write_data(_end), ddr_write_mask
//   ddr_read_data(_valid/_end)                        read return
//   ddr_burst                 constant 1 (BL8)
// Build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of
// fixed priority (see ddr_arb_grant). All outputs are registered.
module ddr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MASK_W = DEF_MASK_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_we,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0] req_wdata,
    input  logic [NREQ-1:0][MASK_W-1:0] req_wmask,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    input  logic                        init_calib_complete,
    input  logic                        ddr_cmd_rdy,
    output logic                        ddr_en,
    output logic [2:0]                  ddr_cmd,
    output logic [ADDR_W-1:0]           memory_address,
    input  logic                        ddr_write_rdy,
    output logic                        ddr_write_en,
    output logic [DATA_W-1:0]           ddr_write_data,
    output logic                        ddr_write_data_end,
    output logic [MASK_W-1:0]           ddr_write_mask,
    input  logic [DATA_W-1:0]           ddr_read_data,
    input  logic                        ddr_read_data_valid,
    input  logic                        ddr_read_data_end,
    output logic                        ddr_burst
);

    state_t            state;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   gnt_q;
    logic              we_q;
    logic              arb_go;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;

    // No grant in the cycle a response is being presented: the served
    // requester gets a chance to re-request before the next decision.
    assign arb_go = (state == ARB) && (|req_valid) && !(|rsp_valid);

    ddr_arb_grant #(.NREQ(NREQ)) u_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .clk       (clk),
        .rst       (rst),
        .take      (arb_go),
`endif
        .req_valid (req_valid),
        .grant     (grant)
    );

    // One-hot AND-OR select of the winning request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i];
                sel_wdata = req_wdata[i];
                sel_wmask = req_wmask[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= WAIT_CAL;
            gnt_q              <= '0;
            we_q               <= 1'b0;
            req_ready          <= '0;
            rsp_valid          <= '0;
            rsp_rdata          <= '0;
            ddr_en             <= 1'b0;
            ddr_cmd            <= DDR_CMD_WRITE;
            memory_address     <= '0;
            ddr_write_en       <= 1'b0;
            ddr_write_data     <= '0;
            ddr_write_data_end <= 1'b0;
            ddr_write_mask     <= '0;
            ddr_burst          <= 1'b1;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            ddr_burst <= 1'b1;
            case (state)
                WAIT_CAL: begin
                    if (init_calib_complete) state <= ARB;
                end
                ARB: begin
                    if (arb_go) begin
                        req_ready      <= grant;
                        gnt_q          <= grant;
                        we_q           <= sel_we;
                        ddr_cmd        <= sel_we ? DDR_CMD_WRITE : DDR_CMD_READ;
                        memory_address <= sel_addr;
                        ddr_write_data <= sel_wdata;
                        ddr_write_mask <= sel_wmask;
                        ddr_en         <= 1'b1;
                        state          <= CMD;
                    end
                end
                CMD: begin
                    if (ddr_cmd_rdy) begin
                        ddr_en <= 1'b0;
                        if (we_q) begin
                            ddr_write_en       <= 1'b1;
                            ddr_write_data_end <= 1'b1;
                            state              <= WDATA;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                WDATA: begin
                    if (ddr_write_rdy) begin
                        ddr_write_en       <= 1'b0;
                        ddr_write_data_end <= 1'b0;
                        rsp_valid          <= gnt_q;
                        state              <= ARB;
                    end
                end
                RDATA: begin
                    // Single BL8 beat: valid and end arrive together.
                    if (ddr_read_data_valid && ddr_read_data_end) begin
                        rsp_rdata <= ddr_read_data;
                        rsp_valid <= gnt_q;
                        state     <= ARB;
                    end
                end
                default: state <= WAIT_CAL;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
module tb_ddr_arbiter;
    import ddr_arb_pkg::*;

    localparam int NREQ = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_we = '0;
    logic [NREQ-1:0][28:0] req_addr = '0;
    logic [NREQ-1:0][255:0] req_wdata = '0;
    logic [NREQ-1:0][31:0] req_wmask = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [255:0]          rsp_rdata;
    logic                  init_calib_complete = 1'b0;
    logic                  ddr_cmd_rdy = 1'b0;
    logic                  ddr_en;
    logic [2:0]            ddr_cmd;
    logic [28:0]           memory_address;
    logic                  ddr_write_rdy = 1'b0;
    logic                  ddr_write_en;
    logic [255:0]          ddr_write_data;
    logic                  ddr_write_data_end;
    logic [31:0]           ddr_write_mask;
    logic [255:0]          ddr_read_data = '0;
    logic                  ddr_read_data_valid = 1'b0;
    logic                  ddr_read_data_end = 1'b0;
    logic                  ddr_burst;

    always #5 clk = ~clk;

    ddr_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .init_calib_complete(init_calib_complete),
        .ddr_cmd_rdy(ddr_cmd_rdy), .ddr_en(ddr_en), .ddr_cmd(ddr_cmd),
        .memory_address(memory_address),
        .ddr_write_rdy(ddr_write_rdy), .ddr_write_en(ddr_write_en),
        .ddr_write_data(ddr_write_data), .ddr_write_data_end(ddr_write_data_end),
        .ddr_write_mask(ddr_write_mask),
        .ddr_read_data(ddr_read_data), .ddr_read_data_valid(ddr_read_data_valid),
        .ddr_read_data_end(ddr_read_data_end), .ddr_burst(ddr_burst)
    );

    // Reference model state: outstanding request count per port, last winner,
    // last read data returned.
    int           checks = 0;
    int           errors = 0;
    int           cnt[NREQ];
    int           model_last = NREQ - 1;
    logic [255:0] last_rdata = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int p);
        logic [NREQ-1:0] v;
        v = '0;
        if (p >= 0 && p < NREQ) v[p] = 1'b1;
        return v;
    endfunction

    // Who the arbitration rules say should win among ports still requesting.
    function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (model_last + k) % NREQ;
            if (cnt[c] > 0) return c;
        end
`else
        for (int c = NREQ - 1; c >= 0; c--) if (cnt[c] > 0) return c;
`endif
        return -1;
    endfunction

    task automatic arm(input int p);
        req_valid[p] = 1'b1;
        req_we[p]    = 1'($urandom_range(0, 1));
        req_addr[p]  = 29'($urandom);
        req_wdata[p] = rnd256();
        req_wmask[p] = $urandom;
    endtask

    task automatic wait_grant(input int bound, output int g);
        int n;
        n = 0;
        while (req_ready == '0 && n < bound) begin
            step();
            n++;
        end
        g = pick();
        chk("grant", req_ready, onehot(g));
        if (g >= 0) begin
            req_valid[g] = 1'b0;
            cnt[g]--;
            model_last = g;
        end
    endtask

    // Drive the DDR side of one granted transaction and check it end to end.
    task automatic serve(input int g, input int cs, input int ws, input int rl,
                         input logic [255:0] rd);
        int n;
        if (g < 0) return;
        n = 0;
        while (ddr_en && n < 20) begin
            n++;
            chk("ddr_cmd", ddr_cmd, req_we[g] ? 3'b000 : 3'b001);
            chk("cmd_addr", memory_address, req_addr[g]);
            ddr_cmd_rdy = (n > cs);
            step();
        end
        ddr_cmd_rdy = 1'b0;
        chk("cmd_cycles", n, cs + 1);
        if (req_we[g]) begin
            n = 0;
            while (ddr_write_en && n < 20) begin
                n++;
                chk("wdata", ddr_write_data, req_wdata[g]);
                chk("wmask", ddr_write_mask, req_wmask[g]);
                chk("wend", ddr_write_data_end, 1'b1);
                ddr_write_rdy = (n > ws);
                step();
            end
            ddr_write_rdy = 1'b0;
            chk("wr_cycles", n, ws + 1);
        end else begin
            for (int i = 0; i < rl; i++) begin
                ddr_read_data       = rnd256();
                ddr_read_data_valid = 1'b1;
                ddr_read_data_end   = 1'b0;
                step();
                chk("no_early_rsp", rsp_valid, '0);
            end
            ddr_read_data       = rd;
            ddr_read_data_valid = 1'b1;
            ddr_read_data_end   = 1'b1;
            step();
            ddr_read_data_valid = 1'b0;
            ddr_read_data_end   = 1'b0;
            last_rdata = rd;
            chk("rsp_rdata", rsp_rdata, rd);
        end
        chk("rsp_valid", rsp_valid, onehot(g));
        step();
        chk("rsp_pulse", rsp_valid, '0);
        chk("rdata_hold", rsp_rdata, last_rdata);
    endtask

    task automatic run_pending();
        int g;
        int guard;
        guard = 0;
        while ((cnt[0] + cnt[1]) > 0 && guard < 20) begin
            guard++;
            wait_grant(10, g);
            serve(g, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rnd256());
            // Re-request in the cycle after the response.
            if (g >= 0 && cnt[g] > 0) arm(g);
        end
    endtask

    initial begin
        int  g;
        logic seen;
        cnt[0] = 0;
        cnt[1] = 0;

        // Reset state
        step(); step(); step();
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_ddr_en", ddr_en, 1'b0);
        chk("rst_ddr_cmd", ddr_cmd, 3'b000);
        chk("rst_addr", memory_address, '0);
        chk("rst_wr_en", ddr_write_en, 1'b0);
        chk("rst_wr_end", ddr_write_data_end, 1'b0);
        chk("rst_burst", ddr_burst, 1'b1);
        chk("rst_state", dut.state, WAIT_CAL);

        // Calibration gate with a pending IF read
        rst = 1'b0;
        arm(0);
        req_we[0]   = 1'b0;
        req_addr[0] = 29'h0000100;
        cnt[0]      = 1;
        seen        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (req_ready != '0) seen = 1'b1;
        end
        chk("cal_gate", seen, 1'b0);
        init_calib_complete = 1'b1;
        wait_grant(2, g);

        // Read with 3-cycle command stall, A5 data
        serve(g, 3, 0, 0, {32{8'hA5}});

        // MEM write to top address with 2-cycle write-data stall
        arm(1);
        req_we[1]    = 1'b1;
        req_addr[1]  = 29'h1FFFFFFF;
        req_wmask[1] = 32'h0000000F;
        cnt[1]       = 1;
        wait_grant(10, g);
        serve(g, 0, 2, 0, '0);

        // Simultaneous requests
        arm(0);
        arm(1);
        cnt[0] = 1;
        cnt[1] = 1;
        run_pending();

        // Both held for four transactions
        arm(0);
        arm(1);
        cnt[0] = 2;
        cnt[1] = 2;
        run_pending();

        // Stray read data while idle in ARB
        step();
        ddr_read_data       = rnd256();
        ddr_read_data_valid = 1'b1;
        ddr_read_data_end   = 1'b1;
        step();
        ddr_read_data_valid = 1'b0;
        ddr_read_data_end   = 1'b0;
        chk("stray_rsp", rsp_valid, '0);
        chk("stray_state", dut.state, ARB);
        chk("stray_rdata", rsp_rdata, last_rdata);

        // Reset in the middle of a read
        arm(0);
        req_we[0] = 1'b0;
        cnt[0]    = 1;
        wait_grant(10, g);
        ddr_cmd_rdy = 1'b1;
        step();
        ddr_cmd_rdy = 1'b0;
        chk("pre_rst_state", dut.state, RDATA);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", dut.state, WAIT_CAL);
        chk("mid_rst_ddr_en", ddr_en, 1'b0);
        chk("mid_rst_cmd", ddr_cmd, 3'b000);
        chk("mid_rst_burst", ddr_burst, 1'b1);
        ddr_read_data       = rnd256();
        ddr_read_data_valid = 1'b1;
        ddr_read_data_end   = 1'b1;
        step();
        ddr_read_data_valid = 1'b0;
        ddr_read_data_end   = 1'b0;
        chk("rst_no_rsp", rsp_valid, '0);
        chk("rst_rdata", rsp_rdata, '0);
        chk("rst_state_hold", dut.state, WAIT_CAL);
        rst        = 1'b0;
        model_last = NREQ - 1;
        last_rdata = '0;

        // Randomized rounds against the model
        for (int r = 0; r < 30; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            for (int p = 0; p < NREQ; p++) begin
                if (sel[p]) begin
                    arm(p);
                    cnt[p] = $urandom_range(1, 2);
                end
            end
            run_pending();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
